i2c_reg_bridge: RTL and testbench
=================================

Name: i2c_reg_bridge

Overview:
Transaction layer between the I2C byte engine (i2c_slave) and the register file (registers) inside tcpc. It turns the start/stop/byte event stream into byte-granular register accesses on the REQUEST/ACK bus. It keeps the TCPCI register pointer, which auto-increments with wrap. It stretches the bus via BUSY while an access is outstanding, and guards against a missing ACK with a timeout.

Parameters:
ACK_TIMEOUT, 64, cycles REQUEST may stay high without ACK before the access is abandoned (min 2).
TO_W, $clog2(ACK_TIMEOUT+1), timeout counter width (derived; not overridden).

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  synchronous active-low reset
START  input  1  pulse: address matched, (repeated) start
STOP  input  1  pulse: stop condition seen
RD_MODE  input  1  R/W bit of address byte, valid with START (1 = master reads)
RX_VALID  input  1  pulse: RX_BYTE written by master
RX_BYTE  input  8  received byte
TX_REQ  input  1  pulse: byte engine needs next read byte
TX_BYTE  output  8  byte to send, valid with TX_VALID
TX_VALID  output  1  pulse: TX_BYTE ready
BUSY  output  1  access outstanding; byte engine stretches SCL
ERR  output  1  pulse: timeout or protocol violation
REQUEST  output  1  register access request
RNW  output  1  1 = read, 0 = write
ADDR  output  8  register byte address
WR_DATA  output  16  write data, {8'h00, byte}
RD_DATA  input  16  read data, low byte used
ACK  input  1  pulse: access done, RD_DATA valid same cycle

Behaviour:
- Reset (RESET_N low at a rising edge): state S_IDLE, ptr=8'h00, REQUEST=0, RNW=1, ADDR=0, WR_DATA=0, TX_BYTE=0, TX_VALID=0, BUSY=0, ERR=0, timeout counter=0, pending flags clear.
- Reset mid-access drops REQUEST at once; no completion is reported.
- States:
  - S_IDLE
  - S_WR_PTR: next byte is the pointer
  - S_WR_DATA
  - S_WR_ACC
  - S_RD_WAIT
  - S_RD_ACC
- START in S_IDLE, S_WR_PTR, S_WR_DATA or S_RD_WAIT goes to S_RD_WAIT if RD_MODE=1, else S_WR_PTR. ptr is retained across a repeated start.
- STOP in the same non-access states goes to S_IDLE. ptr is retained.
- If STOP and START arrive in the same cycle, STOP wins.
- S_WR_PTR + RX_VALID: ptr<=RX_BYTE; go to S_WR_DATA. No register access.
- S_WR_DATA + RX_VALID: next cycle REQUEST=1, RNW=0, ADDR=ptr, WR_DATA={8'h00,RX_BYTE}, BUSY=1; go to S_WR_ACC.
- S_RD_WAIT + TX_REQ: next cycle REQUEST=1, RNW=1, ADDR=ptr, BUSY=1; go to S_RD_ACC.
- Reads are demand-fetched only; no prefetch, so read side effects occur only for bytes the master actually consumes.
- Request handshake:
  - REQUEST, RNW, ADDR and WR_DATA are held stable until ACK is sampled high.
  - REQUEST=0 and BUSY=0 the cycle after ACK, with ptr<=ptr+1 (8-bit wrap, 0xFF to 0x00).
  - Minimum access: request issued 1 cycle after the event; completion 1 cycle after ACK.
- Read completion: TX_BYTE<=RD_DATA[7:0] and TX_VALID=1 for one cycle, in the cycle after ACK; return to S_RD_WAIT.
- Write completion: return to S_WR_DATA.
- Timeout:
  - Counter clears when a request is issued and increments each cycle REQUEST is high.
  - When it reaches ACK_TIMEOUT: REQUEST=0, BUSY=0, ERR pulse, ptr still increments.
  - For a read, TX_BYTE=8'hFF with a TX_VALID pulse.
  - ACK arriving in the same cycle as expiry counts as success.
- START/STOP during S_WR_ACC or S_RD_ACC:
  - The event is latched into pending flags (STOP dominates; RD_MODE is captured with START).
  - The access runs to ACK or timeout, then the pending event is applied instead of the normal return state.
- Protocol violations (each gives a one-cycle ERR pulse and is otherwise ignored):
  - RX_VALID in a read state, S_IDLE or an access state.
  - TX_REQ in a write state, S_IDLE or an access state.
- ACK while REQUEST=0 is ignored.

Decomposition:
- Shared package tcpc_pkg holds:
  - state enum
  - TCPC_ADDR_W=8, TCPC_DATA_W=16
  - RD_ERR_BYTE=8'hFF
- No sub-module; the FSM, pointer and timeout counter are inline.

Test Plan:
1. START(RD_MODE=0), RX 0x10, 0x12, 0x34, STOP, ACK 2 cycles after each REQUEST -> writes ADDR 0x10 WR_DATA 0x0012, then ADDR 0x11 WR_DATA 0x0034, RNW=0; final ptr 0x12; BUSY high only during the accesses.
2. START(0), RX 0x00, START(1), TX_REQ x2, RD_DATA 0x0012 then 0xAB34 -> reads at ADDR 0x00 then 0x01; TX_BYTE 0x12 then 0x34, each with a single TX_VALID pulse.
3. Pointer 0xFF, two data writes -> ADDR 0xFF then 0x00.
4. Read with no ACK -> REQUEST drops exactly 64 cycles after rising; ERR pulse; TX_BYTE 0xFF with TX_VALID; ptr incremented.
5. STOP pulse during S_WR_ACC, ACK 5 cycles later -> REQUEST held until ACK, then S_IDLE; a later RX_VALID without START gives an ERR pulse and no REQUEST.
6. RESET_N low for one edge while REQUEST=1 -> next cycle all outputs at reset values, ptr=0x00; an ACK arriving afterwards is ignored.

Source files
------------

// File: rtl/tcpc_pkg.sv
// Shared types and constants for the tcpc I2C-to-register path.
package tcpc_pkg;

    localparam int TCPC_ADDR_W = 8;
    localparam int TCPC_DATA_W = 16;

    localparam logic [7:0] RD_ERR_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PTR,
        S_WR_DATA,
        S_WR_ACC,
        S_RD_WAIT,
        S_RD_ACC
    } state_t;

    // Where a transaction goes after a start/stop event (stop dominates).
    function automatic state_t event_state(input logic stop, input logic start,
                                           input logic rd, input state_t normal);
        if (stop)
            return S_IDLE;
        else if (start)
            return rd ? S_RD_WAIT : S_WR_PTR;
        else
            return normal;
    endfunction

endpackage

// File: rtl/i2c_reg_bridge.sv
// Turns I2C start/stop/byte events into byte register accesses with an auto-incrementing pointer.
// Request one cycle after the byte event, done one cycle after ACK; BUSY stretches SCL meanwhile, timeout abandons.
module i2c_reg_bridge
    import tcpc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   START,
    input  logic                   STOP,
    input  logic                   RD_MODE,
    input  logic                   RX_VALID,
    input  logic [7:0]             RX_BYTE,
    input  logic                   TX_REQ,
    output logic [7:0]             TX_BYTE,
    output logic                   TX_VALID,
    output logic                   BUSY,
    output logic                   ERR,
    output logic                   REQUEST,
    output logic                   RNW,
    output logic [TCPC_ADDR_W-1:0] ADDR,
    output logic [TCPC_DATA_W-1:0] WR_DATA,
    input  logic [TCPC_DATA_W-1:0] RD_DATA,
    input  logic                   ACK
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    state_t                   state, state_nxt;
    logic [TCPC_ADDR_W-1:0]   ptr, ptr_nxt;
    logic [TO_W-1:0]          to_cnt, to_nxt;
    logic                     pend_stop, pend_stop_nxt;
    logic                     pend_start, pend_start_nxt;
    logic                     pend_rd, pend_rd_nxt;

    logic [7:0]               tx_byte_nxt;
    logic                     tx_valid_nxt, busy_nxt, err_nxt, req_nxt, rnw_nxt;
    logic [TCPC_ADDR_W-1:0]   addr_nxt;
    logic [TCPC_DATA_W-1:0]   wr_data_nxt;

    logic                     in_acc, done, expire;

    // Only the low byte of read data is ever returned to the master.
    logic unused_rd_hi;
    assign unused_rd_hi = ^RD_DATA[TCPC_DATA_W-1:8];

    assign in_acc = (state == S_WR_ACC) || (state == S_RD_ACC);
    assign done   = in_acc && REQUEST && ACK;
    assign expire = in_acc && REQUEST && !ACK && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        to_nxt         = to_cnt;
        pend_stop_nxt  = pend_stop;
        pend_start_nxt = pend_start;
        pend_rd_nxt    = pend_rd;
        tx_byte_nxt    = TX_BYTE;
        tx_valid_nxt   = 1'b0;
        err_nxt        = 1'b0;
        busy_nxt       = BUSY;
        req_nxt        = REQUEST;
        rnw_nxt        = RNW;
        addr_nxt       = ADDR;
        wr_data_nxt    = WR_DATA;

        if (!in_acc) begin
            if (STOP) begin
                state_nxt = S_IDLE;
            end else if (START) begin
                state_nxt = RD_MODE ? S_RD_WAIT : S_WR_PTR;
            end else begin
                if (RX_VALID) begin
                    case (state)
                        S_WR_PTR: begin
                            ptr_nxt   = RX_BYTE;
                            state_nxt = S_WR_DATA;
                        end
                        S_WR_DATA: begin
                            req_nxt     = 1'b1;
                            busy_nxt    = 1'b1;
                            rnw_nxt     = 1'b0;
                            addr_nxt    = ptr;
                            wr_data_nxt = {8'h00, RX_BYTE};
                            to_nxt      = '0;
                            state_nxt   = S_WR_ACC;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
                if (TX_REQ) begin
                    if (state == S_RD_WAIT) begin
                        req_nxt   = 1'b1;
                        busy_nxt  = 1'b1;
                        rnw_nxt   = 1'b1;
                        addr_nxt  = ptr;
                        to_nxt    = '0;
                        state_nxt = S_RD_ACC;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        end else begin
            if (STOP) begin
                pend_stop_nxt = 1'b1;
            end else if (START) begin
                pend_start_nxt = 1'b1;
                pend_rd_nxt    = RD_MODE;
            end
            if (RX_VALID || TX_REQ)
                err_nxt = 1'b1;

            if (done || expire) begin
                req_nxt  = 1'b0;
                busy_nxt = 1'b0;
                ptr_nxt  = ptr + 8'd1;
                if (expire)
                    err_nxt = 1'b1;
                if (state == S_RD_ACC) begin
                    tx_valid_nxt = 1'b1;
                    tx_byte_nxt  = done ? RD_DATA[7:0] : RD_ERR_BYTE;
                end
                // An event seen during the access replaces the normal return state.
                state_nxt = event_state(pend_stop_nxt, pend_start_nxt, pend_rd_nxt,
                                        (state == S_RD_ACC) ? S_RD_WAIT : S_WR_DATA);
                pend_stop_nxt  = 1'b0;
                pend_start_nxt = 1'b0;
                pend_rd_nxt    = 1'b0;
            end else begin
                to_nxt = to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            ptr        <= '0;
            to_cnt     <= '0;
            pend_stop  <= 1'b0;
            pend_start <= 1'b0;
            pend_rd    <= 1'b0;
            TX_BYTE    <= '0;
            TX_VALID   <= 1'b0;
            BUSY       <= 1'b0;
            ERR        <= 1'b0;
            REQUEST    <= 1'b0;
            RNW        <= 1'b1;
            ADDR       <= '0;
            WR_DATA    <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            to_cnt     <= to_nxt;
            pend_stop  <= pend_stop_nxt;
            pend_start <= pend_start_nxt;
            pend_rd    <= pend_rd_nxt;
            TX_BYTE    <= tx_byte_nxt;
            TX_VALID   <= tx_valid_nxt;
            BUSY       <= busy_nxt;
            ERR        <= err_nxt;
            REQUEST    <= req_nxt;
            RNW        <= rnw_nxt;
            ADDR       <= addr_nxt;
            WR_DATA    <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Scoreboard bench for i2c_reg_bridge: expected accesses/TX bytes queued at stimulus, checked on DUT output.
module tb_i2c_reg_bridge;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0, STOP = 1'b0, RD_MODE = 1'b0;
    logic        RX_VALID = 1'b0, TX_REQ = 1'b0, ACK = 1'b0;
    logic [7:0]  RX_BYTE = 8'h00;
    logic [15:0] RD_DATA = 16'h0000;
    logic [7:0]  TX_BYTE, ADDR;
    logic [15:0] WR_DATA;
    logic        TX_VALID, BUSY, ERR, REQUEST, RNW;

    i2c_reg_bridge #(.ACK_TIMEOUT(64)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP), .RD_MODE(RD_MODE),
        .RX_VALID(RX_VALID), .RX_BYTE(RX_BYTE), .TX_REQ(TX_REQ), .TX_BYTE(TX_BYTE),
        .TX_VALID(TX_VALID), .BUSY(BUSY), .ERR(ERR), .REQUEST(REQUEST), .RNW(RNW),
        .ADDR(ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .ACK(ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rnw;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } acc_t;

    acc_t       exp_acc_q[$];
    logic [7:0] exp_tx_q[$];

    int   vectors = 0, miscompares = 0;
    int   err_cnt = 0, tx_cnt = 0, busy_bad = 0, tx_long = 0;
    int   cyc = 0, req_start = 0, last_req_len = 0;
    logic mon_en = 1'b0;
    logic ack_en = 1'b1;
    int   ack_dly = 2;
    logic [7:0] m_ptr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops scoreboard entries on request rise and TX_VALID.
    initial begin
        logic prev_req, prev_txv;
        acc_t e;
        prev_req = 1'b0;
        prev_txv = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (REQUEST === 1'b1 && !prev_req) begin
                    req_start = cyc;
                    if (exp_acc_q.size() == 0) begin
                        chk("unexpected_request", 32'(REQUEST), 32'd0);
                    end else begin
                        e = exp_acc_q.pop_front();
                        chk("acc_rnw", 32'(RNW), 32'(e.rnw));
                        chk("acc_addr", 32'(ADDR), 32'(e.addr));
                        if (!e.rnw)
                            chk("acc_wr_data", 32'(WR_DATA), 32'(e.wdata));
                    end
                end
                if (REQUEST !== 1'b1 && prev_req)
                    last_req_len = cyc - req_start;
                if (TX_VALID === 1'b1) begin
                    tx_cnt++;
                    if (prev_txv) tx_long++;
                    if (exp_tx_q.size() == 0)
                        chk("unexpected_tx_valid", 32'(TX_VALID), 32'd0);
                    else
                        chk("tx_byte", 32'(TX_BYTE), 32'(exp_tx_q.pop_front()));
                end
                if (ERR === 1'b1) err_cnt++;
                if (BUSY !== REQUEST) busy_bad++;
                prev_req = (REQUEST === 1'b1);
                prev_txv = (TX_VALID === 1'b1);
            end
            cyc++;
        end
    end

    // Register-file model: one ACK pulse ack_dly cycles after each request rise.
    initial begin
        logic rp;
        int d;
        rp = 1'b0;
        forever begin
            @(negedge CLK);
            if (REQUEST === 1'b1 && !rp && ack_en) begin
                d = ack_dly;
                repeat (d - 1) @(posedge CLK);
                #1 ACK = 1'b1;
                @(posedge CLK);
                #1 ACK = 1'b0;
            end
            rp = (REQUEST === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic rd);
        START = 1'b1; RD_MODE = rd; tick(); START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1; tick(); STOP = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX_VALID = 1'b1; RX_BYTE = b; tick(); RX_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (BUSY === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("access_done_in_budget", 32'(BUSY), 32'd0);
        tick();
    endtask

    task automatic set_ptr(input logic [7:0] b);
        send_rx(b);
        m_ptr = b;
    endtask

    task automatic write_byte(input logic [7:0] b);
        exp_acc_q.push_back('{1'b0, m_ptr, {8'h00, b}});
        m_ptr = m_ptr + 8'd1;
        send_rx(b);
        wait_done();
    endtask

    task automatic read_byte(input logic [15:0] rd);
        exp_acc_q.push_back('{1'b1, m_ptr, 16'h0000});
        exp_tx_q.push_back(ack_en ? rd[7:0] : 8'hFF);
        m_ptr = m_ptr + 8'd1;
        RD_DATA = rd;
        TX_REQ = 1'b1; tick(); TX_REQ = 1'b0;
        wait_done();
    endtask

    initial begin
        int e0, t0;
        repeat (3) tick();
        RESET_N = 1'b1;
        mon_en = 1'b1;
        chk("rst_request", 32'(REQUEST), 32'd0);
        chk("rst_rnw", 32'(RNW), 32'd1);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_wr_data", 32'(WR_DATA), 32'd0);
        chk("rst_tx", {22'd0, TX_BYTE, TX_VALID, BUSY}, 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);

        // 1: pointer then two writes, pointer verified by a following read
        e0 = err_cnt;
        ack_dly = 2;
        pulse_start(1'b0);
        set_ptr(8'h10);
        write_byte(8'h12);
        chk("t1_req_len", 32'(last_req_len), 32'd2);
        write_byte(8'h34);
        pulse_stop();
        pulse_start(1'b1);
        read_byte(16'h0055);
        pulse_stop();
        chk("t1_err", 32'(err_cnt - e0), 32'd0);

        // 2: write pointer, repeated start, two reads
        t0 = tx_cnt;
        pulse_start(1'b0);
        set_ptr(8'h00);
        pulse_start(1'b1);
        read_byte(16'h0012);
        read_byte(16'hAB34);
        pulse_stop();
        chk("t2_tx_pulses", 32'(tx_cnt - t0), 32'd2);

        // 3: pointer wrap
        pulse_start(1'b0);
        set_ptr(8'hFF);
        write_byte(8'hA1);
        write_byte(8'hA2);
        pulse_stop();

        // 4: read timeout, then a normal read at the incremented pointer
        e0 = err_cnt;
        pulse_start(1'b1);
        ack_en = 1'b0;
        read_byte(16'h0000);
        chk("t4_req_len", 32'(last_req_len), 32'd64);
        chk("t4_err", 32'(err_cnt - e0), 32'd1);
        ack_en = 1'b1;
        read_byte(16'h0077);
        pulse_stop();

        // 5: stop during a write access
        e0 = err_cnt;
        ack_dly = 5;
        pulse_start(1'b0);
        set_ptr(8'h40);
        exp_acc_q.push_back('{1'b0, m_ptr, 16'h0099});
        m_ptr = m_ptr + 8'd1;
        send_rx(8'h99);
        pulse_stop();
        wait_done();
        chk("t5_req_len", 32'(last_req_len), 32'd5);
        send_rx(8'h55);
        repeat (4) tick();
        chk("t5_err", 32'(err_cnt - e0), 32'd1);
        chk("t5_no_request", 32'(REQUEST), 32'd0);

        // 6: reset while a request is outstanding; late ACK must be ignored
        e0 = err_cnt;
        t0 = tx_cnt;
        ack_dly = 6;
        pulse_start(1'b0);
        set_ptr(8'h20);
        exp_acc_q.push_back('{1'b0, 8'h20, 16'h0011});
        send_rx(8'h11);
        tick();
        RESET_N = 1'b0; tick(); RESET_N = 1'b1;
        m_ptr = 8'h00;
        chk("t6_request", 32'(REQUEST), 32'd0);
        chk("t6_busy", 32'(BUSY), 32'd0);
        chk("t6_rnw_addr", {23'd0, RNW, ADDR}, 32'h100);
        chk("t6_wr_data", 32'(WR_DATA), 32'd0);
        repeat (8) tick();
        chk("t6_err", 32'(err_cnt - e0), 32'd0);
        chk("t6_no_tx", 32'(tx_cnt - t0), 32'd0);
        ack_dly = 2;
        pulse_start(1'b1);
        read_byte(16'h00C3);
        pulse_stop();

        repeat (4) tick();
        chk("acc_queue_drained", 32'(exp_acc_q.size()), 32'd0);
        chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        chk("busy_tracks_request", 32'(busy_bad), 32'd0);
        chk("tx_valid_single_cycle", 32'(tx_long), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
